// File: rtl/snes_loader_pkg.sv
// ============================================================================
//  Module      : snes_loader_pkg
//  Description : Shared emitter state type and halfword byte-swap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snes_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } emit_state_t;

    localparam int c_WORD_W = 32;

    // Big-endian halfword from the bridge becomes little-endian for the SNES.
    function automatic logic [15:0] swap_halfword(input logic [15:0] be_half);
        return {be_half[7:0], be_half[15:8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_word_fifo.sv
// ============================================================================
//  Module      : sync_word_fifo
//  Description : Single-clock FIFO; a pop in the same cycle frees room for a push.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW:0]    r_wr_ptr;
    logic [c_PW:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                        (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr[c_PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PW-1:0]] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/rom_word_loader.sv
// ============================================================================
//  Module      : rom_word_loader
//  Description : Buffers 32-bit bridge words and emits them as SDRAM halfwords.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_word_loader
    import snes_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              dl_start,
    input  logic              dl_end,
    input  logic              bridge_wr,
    input  logic [31:0]       bridge_addr,
    input  logic [31:0]       bridge_wr_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data,
    output logic              downloading,
    output logic [31:0]       loaded_bytes,
    output logic              overflow
);

    localparam int c_WA_W    = ADDR_W - 2;
    localparam int c_ENTRY_W = c_WA_W + c_WORD_W;

    emit_state_t          r_state;
    logic                 r_end_pending;
    logic [15:0]          r_lo_half;
    logic [c_ENTRY_W-1:0] w_fifo_out;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start;
    logic                 w_fall;
    logic                 w_hw_acked;
    logic [c_WA_W-1:0]    w_pop_addr;
    logic [31:0]          w_pop_word;
    logic                 w_unused_addr_bits;

    assign w_unused_addr_bits = ^{bridge_addr[1:0], bridge_addr[31:ADDR_W]};

    assign w_start    = dl_start && !downloading;
    assign w_fall     = downloading && r_end_pending && w_fifo_empty && (r_state == S_IDLE);
    assign w_push     = bridge_wr && downloading;
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_HI) && mem_ack));
    assign w_hw_acked = mem_wr && mem_ack;
    assign w_pop_addr = w_fifo_out[c_ENTRY_W-1:c_WORD_W];
    assign w_pop_word = w_fifo_out[c_WORD_W-1:0];

    sync_word_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_mem),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_push_data ({bridge_addr[ADDR_W-1:2], bridge_wr_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            downloading   <= 1'b0;
            r_end_pending <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (w_start) begin
                downloading   <= 1'b1;
                r_end_pending <= 1'b0;
            end else if (w_fall) begin
                downloading   <= 1'b0;
                r_end_pending <= 1'b0;
            end else if (dl_end && downloading) begin
                r_end_pending <= 1'b1;
            end

            if (w_start)
                overflow <= 1'b0;
            else if (w_push && w_fifo_full && !w_pop)
                overflow <= 1'b1;
        end
    end

    // The high halfword of the word being emitted goes out first (lower address).
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            mem_wr       <= 1'b0;
            addr         <= '0;
            data         <= '0;
            r_lo_half    <= '0;
            loaded_bytes <= '0;
        end else begin
            if (w_start)
                loaded_bytes <= '0;
            else if (w_hw_acked)
                loaded_bytes <= loaded_bytes + 32'd2;

            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_state   <= S_LO;
                        mem_wr    <= 1'b1;
                        addr      <= {w_pop_addr, 2'b00};
                        data      <= swap_halfword(w_pop_word[31:16]);
                        r_lo_half <= w_pop_word[15:0];
                    end
                end
                S_LO: begin
                    if (mem_ack) begin
                        r_state <= S_HI;
                        addr    <= {addr[ADDR_W-1:2], 2'b10};
                        data    <= swap_halfword(r_lo_half);
                    end
                end
                S_HI: begin
                    if (mem_ack) begin
                        if (!w_fifo_empty) begin
                            r_state   <= S_LO;
                            addr      <= {w_pop_addr, 2'b00};
                            data      <= swap_halfword(w_pop_word[31:16]);
                            r_lo_half <= w_pop_word[15:0];
                        end else begin
                            r_state <= S_IDLE;
                            mem_wr  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
